// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side control bundle between the datapath (master) and pipe_hazard_ctrl (slave).
interface pipe_hazard_ctrl_if #(parameter int REG_AW = 6);
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_regwrt;
   logic              ex_memrd;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_regwrt;
   logic              redirect;
   logic              ext_stall;
   logic              pc_wr_en;
   logic              ifid_wr_en;
   logic              ifid_flush;
   logic              idex_bubble;
   logic              pc_sel_redirect;
   logic              busy;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_regwrt, ex_memrd,
             mem_rd, mem_regwrt, redirect, ext_stall,
      input  pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, pc_sel_redirect, busy
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_regwrt, ex_memrd,
             mem_rd, mem_regwrt, redirect, ext_stall,
      output pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, pc_sel_redirect, busy
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// RUN/STALL/FLUSH sequencer for PC, IF/ID and ID/EX controls.
// Define PIPECTRL_FWD_EN when the datapath forwards, so only load-use hazards stall.
module pipe_hazard_ctrl #(
   parameter int LOAD_USE_STALL = 1,
   parameter int BRANCH_FLUSH   = 2,
   parameter int REG_AW         = 6
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_t;

   localparam logic [3:0] STALL_RELOAD = 4'(LOAD_USE_STALL - 1);
   localparam logic [3:0] FLUSH_RELOAD = 4'(BRANCH_FLUSH - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [REG_AW-1:0] rs, rt;
   logic              ex_match, mem_match, hz_long, hz_short;

   assign rs = bus.id_rs;
   assign rt = bus.id_rt;
   assign ex_match  = (bus.id_uses_rs & (rs == bus.ex_rd))  | (bus.id_uses_rt & (rt == bus.ex_rd));
   assign mem_match = (bus.id_uses_rs & (rs == bus.mem_rd)) | (bus.id_uses_rt & (rt == bus.mem_rd));

   // hz_long uses the full stall length; hz_short is a MEM-stage match that only ever costs one cycle.
`ifdef PIPECTRL_FWD_EN
   assign hz_long  = bus.ex_memrd & bus.ex_regwrt & ex_match;
   assign hz_short = 1'b0 & mem_match & bus.mem_regwrt;
`else
   assign hz_long  = bus.ex_regwrt & ex_match;
   assign hz_short = bus.mem_regwrt & mem_match;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      cnt_d               = cnt_q;
      bus.pc_wr_en        = 1'b1;
      bus.ifid_wr_en      = 1'b1;
      bus.ifid_flush      = 1'b0;
      bus.idex_bubble     = 1'b0;
      bus.pc_sel_redirect = 1'b0;

      if (bus.redirect) begin
         bus.pc_sel_redirect = 1'b1;
         bus.ifid_flush      = 1'b1;
         bus.idex_bubble     = 1'b1;
         if (BRANCH_FLUSH > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
         end else begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
         end
      end else if (bus.ext_stall) begin
         bus.pc_wr_en   = 1'b0;
         bus.ifid_wr_en = 1'b0;
      end else begin
         case (state_q)
            ST_STALL: begin
               bus.pc_wr_en    = 1'b0;
               bus.ifid_wr_en  = 1'b0;
               bus.idex_bubble = 1'b1;
               cnt_d           = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = ST_RUN;
            end
            ST_FLUSH: begin
               bus.ifid_flush  = 1'b1;
               bus.idex_bubble = 1'b1;
               cnt_d           = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = ST_RUN;
            end
            default: begin
               if (hz_long || hz_short) begin
                  bus.pc_wr_en    = 1'b0;
                  bus.ifid_wr_en  = 1'b0;
                  bus.idex_bubble = 1'b1;
                  if (hz_long && (LOAD_USE_STALL > 1)) begin
                     state_d = ST_STALL;
                     cnt_d   = STALL_RELOAD;
                  end
               end
            end
         endcase
      end

      // Reset forces a NOP into the front end regardless of state.
      if (rst) begin
         bus.pc_wr_en        = 1'b0;
         bus.ifid_wr_en      = 1'b0;
         bus.ifid_flush      = 1'b1;
         bus.idex_bubble     = 1'b1;
         bus.pc_sel_redirect = 1'b0;
      end
   end

   assign bus.busy = (state_q != ST_RUN) & ~rst;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LUS=2/BF=2 and LUS=3/BF=3) checked against a
// remaining-cycles model every cycle, plus directed literal checks.
module tb_pipe_hazard_ctrl;
   localparam int LUS_A = 2, BF_A = 2, LUS_B = 3, BF_B = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] id_rs, id_rt, ex_rd, mem_rd;
   logic       id_uses_rs, id_uses_rt, ex_regwrt, ex_memrd, mem_regwrt, redirect, ext_stall;

   int tests_run    = 0;
   int tests_failed = 0;

   pipe_hazard_ctrl_if #(.REG_AW(6)) bus_a ();
   pipe_hazard_ctrl_if #(.REG_AW(6)) bus_b ();

   assign bus_a.id_rs = id_rs;           assign bus_b.id_rs = id_rs;
   assign bus_a.id_rt = id_rt;           assign bus_b.id_rt = id_rt;
   assign bus_a.id_uses_rs = id_uses_rs; assign bus_b.id_uses_rs = id_uses_rs;
   assign bus_a.id_uses_rt = id_uses_rt; assign bus_b.id_uses_rt = id_uses_rt;
   assign bus_a.ex_rd = ex_rd;           assign bus_b.ex_rd = ex_rd;
   assign bus_a.ex_regwrt = ex_regwrt;   assign bus_b.ex_regwrt = ex_regwrt;
   assign bus_a.ex_memrd = ex_memrd;     assign bus_b.ex_memrd = ex_memrd;
   assign bus_a.mem_rd = mem_rd;         assign bus_b.mem_rd = mem_rd;
   assign bus_a.mem_regwrt = mem_regwrt; assign bus_b.mem_regwrt = mem_regwrt;
   assign bus_a.redirect = redirect;     assign bus_b.redirect = redirect;
   assign bus_a.ext_stall = ext_stall;   assign bus_b.ext_stall = ext_stall;

   pipe_hazard_ctrl #(.LOAD_USE_STALL(LUS_A), .BRANCH_FLUSH(BF_A), .REG_AW(6)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave));
   pipe_hazard_ctrl #(.LOAD_USE_STALL(LUS_B), .BRANCH_FLUSH(BF_B), .REG_AW(6)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b.slave));

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [5:0] act, input logic [5:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   // Model: the front end owes some number of frozen cycles or squashed slots.
   int m_stall[2] = '{0, 0};
   int m_flush[2] = '{0, 0};
   int n_stall[2] = '{0, 0};
   int n_flush[2] = '{0, 0};

   function automatic logic [5:0] dut_vec(input int k);
      if (k == 0)
         return {bus_a.pc_wr_en, bus_a.ifid_wr_en, bus_a.ifid_flush, bus_a.idex_bubble,
                 bus_a.pc_sel_redirect, bus_a.busy};
      return {bus_b.pc_wr_en, bus_b.ifid_wr_en, bus_b.ifid_flush, bus_b.idex_bubble,
              bus_b.pc_sel_redirect, bus_b.busy};
   endfunction

   always @(negedge clk) begin
      logic ex_hit, mem_hit, long_hz, short_hz, owed;
      logic [5:0] exp;
      int lus, bf;
      ex_hit  = (id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd);
      mem_hit = (id_uses_rs && id_rs == mem_rd) || (id_uses_rt && id_rt == mem_rd);
`ifdef PIPECTRL_FWD_EN
      long_hz  = ex_hit && ex_memrd && ex_regwrt;
      short_hz = 1'b0;
`else
      long_hz  = ex_hit && ex_regwrt;
      short_hz = mem_hit && mem_regwrt;
`endif
      for (int k = 0; k < 2; k++) begin
         lus  = (k == 0) ? LUS_A : LUS_B;
         bf   = (k == 0) ? BF_A : BF_B;
         owed = (m_stall[k] > 0) || (m_flush[k] > 0);
         n_stall[k] = m_stall[k];
         n_flush[k] = m_flush[k];
         if (rst) begin
            exp = 6'b001100;
            n_stall[k] = 0;
            n_flush[k] = 0;
         end else if (redirect) begin
            exp = {5'b11111, owed};
            n_stall[k] = 0;
            n_flush[k] = bf - 1;
         end else if (ext_stall) begin
            exp = {5'b00000, owed};
         end else if (m_stall[k] > 0) begin
            exp = 6'b000101;
            n_stall[k] = m_stall[k] - 1;
         end else if (m_flush[k] > 0) begin
            exp = 6'b111101;
            n_flush[k] = m_flush[k] - 1;
         end else if (long_hz) begin
            exp = 6'b000100;
            n_stall[k] = lus - 1;
         end else if (short_hz) begin
            exp = 6'b000100;
         end else begin
            exp = 6'b110000;
         end
         checkOutput((k == 0) ? "model_a" : "model_b", dut_vec(k), exp);
      end
   end

   always @(posedge clk) begin
      m_stall <= n_stall;
      m_flush <= n_flush;
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic clearInputs();
      id_rs = 6'd0; id_rt = 6'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      ex_rd = 6'd0; ex_regwrt = 1'b0; ex_memrd = 1'b0;
      mem_rd = 6'd0; mem_regwrt = 1'b0; redirect = 1'b0; ext_stall = 1'b0;
   endtask

   task automatic applyStimulus(input logic [5:0] rs, input logic urs, input logic [5:0] rt,
                                input logic urt, input logic [5:0] erd, input logic ew,
                                input logic em, input logic [5:0] mrd, input logic mw);
      id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
      ex_rd = erd; ex_regwrt = ew; ex_memrd = em; mem_rd = mrd; mem_regwrt = mw;
   endtask

   typedef struct {
      logic [5:0] rs; logic urs; logic [5:0] rt; logic urt;
      logic [5:0] erd; logic ew; logic em; logic [5:0] mrd; logic mw;
      logic redir; logic xs;
   } vec_t;

   vec_t table_v[8];
   logic fwd_build;

   initial begin
`ifdef PIPECTRL_FWD_EN
      fwd_build = 1'b1;
`else
      fwd_build = 1'b0;
`endif
      table_v[0] = '{6'd0, 1'b1, 6'd3, 1'b0, 6'd0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0};
      table_v[1] = '{6'd4, 1'b0, 6'd4, 1'b0, 6'd4, 1'b1, 1'b1, 6'd4, 1'b1, 1'b0, 1'b0};
      table_v[2] = '{6'd1, 1'b1, 6'd12, 1'b1, 6'd12, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0};
      table_v[3] = '{6'd8, 1'b1, 6'd2, 1'b1, 6'd8, 1'b1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b0};
      table_v[4] = '{6'd8, 1'b1, 6'd2, 1'b1, 6'd8, 1'b1, 1'b1, 6'd2, 1'b1, 1'b0, 1'b1};
      table_v[5] = '{6'd63, 1'b1, 6'd5, 1'b0, 6'd63, 1'b0, 1'b1, 6'd9, 1'b1, 1'b0, 1'b0};
      table_v[6] = '{6'd10, 1'b1, 6'd11, 1'b1, 6'd20, 1'b1, 1'b1, 6'd11, 1'b1, 1'b0, 1'b0};
      table_v[7] = '{6'd33, 1'b1, 6'd0, 1'b0, 6'd33, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0};

      clearInputs();
      rst = 1'b1;
      settle();
      checkOutput("reset_pc_wr_en", 6'(bus_a.pc_wr_en), 6'd0);
      checkOutput("reset_ifid_flush", 6'(bus_a.ifid_flush), 6'd1);
      checkOutput("reset_idex_bubble", 6'(bus_a.idex_bubble), 6'd1);
      checkOutput("reset_busy", 6'(bus_a.busy), 6'd0);
      nextCycle();
      nextCycle();
      rst = 1'b0;
      settle();
      checkOutput("run_pc_wr_en", 6'(bus_a.pc_wr_en), 6'd1);

      // Load-use on r5.
      nextCycle();
      applyStimulus(6'd5, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1, 6'd0, 1'b0);
      settle();
      checkOutput("lu_c1_pc", 6'(bus_a.pc_wr_en), 6'd0);
      checkOutput("lu_c1_bubble", 6'(bus_a.idex_bubble), 6'd1);
      checkOutput("lu_c1_busy", 6'(bus_a.busy), 6'd0);
      nextCycle();
      clearInputs();
      settle();
      checkOutput("lu_c2_pc", 6'(bus_a.pc_wr_en), 6'd0);
      checkOutput("lu_c2_busy", 6'(bus_a.busy), 6'd1);
      nextCycle();
      settle();
      checkOutput("lu_c3_pc_a", 6'(bus_a.pc_wr_en), 6'd1);
      checkOutput("lu_c3_pc_b", 6'(bus_b.pc_wr_en), 6'd0);
      nextCycle();
      settle();
      checkOutput("lu_c4_pc_b", 6'(bus_b.pc_wr_en), 6'd1);

      // Taken branch.
      nextCycle();
      redirect = 1'b1;
      settle();
      checkOutput("br_c1_sel", 6'(bus_a.pc_sel_redirect), 6'd1);
      checkOutput("br_c1_flush", 6'(bus_a.ifid_flush), 6'd1);
      nextCycle();
      redirect = 1'b0;
      settle();
      checkOutput("br_c2_sel", 6'(bus_a.pc_sel_redirect), 6'd0);
      checkOutput("br_c2_flush", 6'(bus_a.ifid_flush), 6'd1);
      nextCycle();
      settle();
      checkOutput("br_c3_flush_a", 6'(bus_a.ifid_flush), 6'd0);
      checkOutput("br_c3_flush_b", 6'(bus_b.ifid_flush), 6'd1);
      nextCycle();

      // Redirect in the first STALL cycle.
      applyStimulus(6'd5, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1, 6'd0, 1'b0);
      nextCycle();
      clearInputs();
      redirect = 1'b1;
      settle();
      checkOutput("rs_pc_b", 6'(bus_b.pc_wr_en), 6'd1);
      checkOutput("rs_sel_b", 6'(bus_b.pc_sel_redirect), 6'd1);
      nextCycle();
      redirect = 1'b0;
      settle();
      checkOutput("rs_flush_b", 6'(bus_b.ifid_flush), 6'd1);
      checkOutput("rs_busy_b", 6'(bus_b.busy), 6'd1);
      nextCycle();
      nextCycle();

      // ext_stall held 4 cycles in FLUSH with one slot left (dut_a).
      redirect = 1'b1;
      nextCycle();
      redirect = 1'b0;
      ext_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         checkOutput("xs_pc_a", 6'(bus_a.pc_wr_en), 6'd0);
         checkOutput("xs_flush_a", 6'(bus_a.ifid_flush), 6'd0);
         checkOutput("xs_busy_a", 6'(bus_a.busy), 6'd1);
         nextCycle();
      end
      ext_stall = 1'b0;
      settle();
      checkOutput("xs_rel1_flush_a", 6'(bus_a.ifid_flush), 6'd1);
      nextCycle();
      settle();
      checkOutput("xs_rel2_flush_a", 6'(bus_a.ifid_flush), 6'd0);
      checkOutput("xs_rel2_busy_a", 6'(bus_a.busy), 6'd0);
      nextCycle();
      nextCycle();

      // Reset in the middle of a stall.
      applyStimulus(6'd5, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1, 6'd0, 1'b0);
      nextCycle();
      clearInputs();
      rst = 1'b1;
      settle();
      checkOutput("rst_mid_flush", 6'(bus_b.ifid_flush), 6'd1);
      checkOutput("rst_mid_busy", 6'(bus_b.busy), 6'd0);
      nextCycle();
      rst = 1'b0;
      settle();
      checkOutput("rst_after_busy_b", 6'(bus_b.busy), 6'd0);
      checkOutput("rst_after_pc_b", 6'(bus_b.pc_wr_en), 6'd1);

      // MEM-stage match on r7.
      nextCycle();
      applyStimulus(6'd0, 1'b0, 6'd7, 1'b1, 6'd0, 1'b0, 1'b0, 6'd7, 1'b1);
      settle();
      checkOutput("mem_pc_a", 6'(bus_a.pc_wr_en), 6'(fwd_build));
      checkOutput("mem_pc_b", 6'(bus_b.pc_wr_en), 6'(fwd_build));
      nextCycle();
      clearInputs();
      settle();
      checkOutput("mem_after_pc_b", 6'(bus_b.pc_wr_en), 6'd1);

      // Vector table, each vector for one cycle followed by enough idle cycles to drain.
      for (int v = 0; v < 8; v++) begin
         nextCycle();
         applyStimulus(table_v[v].rs, table_v[v].urs, table_v[v].rt, table_v[v].urt,
                       table_v[v].erd, table_v[v].ew, table_v[v].em, table_v[v].mrd, table_v[v].mw);
         redirect  = table_v[v].redir;
         ext_stall = table_v[v].xs;
         nextCycle();
         clearInputs();
         repeat (4) nextCycle();
      end

      repeat (2) nextCycle();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
